work_sender: RTL and testbench

Controller-side endpoint of the miner's serial work protocol. Accepts a job (midstate and data2), serializes it as a 64-byte 8N1 UART frame toward a miner's RxD, and reassembles the miner's 4-byte golden-nonce replies from its TxD. The block drives miners from a controller FPGA and serves as the host model in system-level benches.

---
 rtl/work_sender.sv | 227 ++++++++++++++++++++++
 tb/tb_work_sender.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/work_sender.sv
// rtl/work_sender.sv - host-side miner work protocol: 64-byte job UART sender and 4-byte nonce receiver
module work_sender #(
   parameter int CLOCK      = 25000000,
   parameter int BAUD       = 115200,
   parameter int GAP_CYCLES = 250000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] midstate,
   input  logic [255:0] data2,
   output logic         busy,
   output logic         tx,
   input  logic         rx,
   output logic [31:0]  nonce,
   output logic         nonce_valid,
   output logic         frame_error
);

   localparam int BIT_CYCLES  = CLOCK / BAUD;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CW          = $clog2(BIT_CYCLES + 1);
   localparam int GW          = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   // ---------------- transmit ----------------
   uart_state_t    tx_state, tx_state_nx;
   logic [CW-1:0]  tx_cnt, tx_cnt_nx;
   logic [2:0]     tx_bit, tx_bit_nx;
   logic [5:0]     tx_byte, tx_byte_nx;
   logic [511:0]   tx_shreg, tx_shreg_nx;
   logic [7:0]     tx_cur;
   logic           tx_nx, busy_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx_shreg <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_bit   <= tx_bit_nx;
         tx_byte  <= tx_byte_nx;
         tx_shreg <= tx_shreg_nx;
         tx       <= tx_nx;
         busy     <= busy_nx;
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt + 1'b1;
      tx_bit_nx   = tx_bit;
      tx_byte_nx  = tx_byte;
      tx_shreg_nx = tx_shreg;
      case (tx_state)
         S_IDLE: begin
            tx_cnt_nx = '0;
            if (start) begin
               tx_shreg_nx = {data2, midstate};
               tx_byte_nx  = '0;
               tx_bit_nx   = '0;
               tx_state_nx = S_START;
            end
         end
         S_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx   = '0;
               tx_bit_nx   = '0;
               tx_state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_bit == 3'd7) tx_state_nx = S_STOP;
               else                tx_bit_nx   = tx_bit + 1'b1;
            end
         end
         S_STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_nx = '0;
               if (tx_byte == 6'd63) begin
                  tx_state_nx = S_IDLE;
               end else begin
                  tx_byte_nx  = tx_byte + 1'b1;
                  tx_shreg_nx = {8'h00, tx_shreg[511:8]};
                  tx_state_nx = S_START;
               end
            end
         end
         default: tx_state_nx = S_IDLE;
      endcase
      // line level is registered from the next state so tx and busy move on the same edge
      tx_cur  = tx_shreg_nx[7:0];
      busy_nx = (tx_state_nx != S_IDLE);
      case (tx_state_nx)
         S_START: tx_nx = 1'b0;
         S_DATA:  tx_nx = tx_cur[tx_bit_nx];
         default: tx_nx = 1'b1;
      endcase
   end

   // ---------------- receive ----------------
   logic           rx_meta, rx_sync;
   uart_state_t    rx_state, rx_state_nx;
   logic [CW-1:0]  rx_cnt, rx_cnt_nx;
   logic [2:0]     rx_bit, rx_bit_nx;
   logic [7:0]     rx_shift, rx_shift_nx;
   logic           rx_hold, rx_hold_nx;
   logic [1:0]     asm_cnt, asm_cnt_nx;
   logic [23:0]    asm_buf, asm_buf_nx;
   logic [GW-1:0]  gap_cnt, gap_cnt_nx;
   logic [31:0]    nonce_nx;
   logic           nonce_valid_nx, frame_error_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_state    <= S_IDLE;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_hold     <= 1'b0;
         asm_cnt     <= '0;
         asm_buf     <= '0;
         gap_cnt     <= '0;
         nonce       <= '0;
         nonce_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rx_sync     <= rx_meta;
         rx_state    <= rx_state_nx;
         rx_cnt      <= rx_cnt_nx;
         rx_bit      <= rx_bit_nx;
         rx_shift    <= rx_shift_nx;
         rx_hold     <= rx_hold_nx;
         asm_cnt     <= asm_cnt_nx;
         asm_buf     <= asm_buf_nx;
         gap_cnt     <= gap_cnt_nx;
         nonce       <= nonce_nx;
         nonce_valid <= nonce_valid_nx;
         frame_error <= frame_error_nx;
      end
   end

   always_comb begin
      rx_state_nx    = rx_state;
      rx_cnt_nx      = rx_cnt + 1'b1;
      rx_bit_nx      = rx_bit;
      rx_shift_nx    = rx_shift;
      rx_hold_nx     = rx_hold;
      asm_cnt_nx     = asm_cnt;
      asm_buf_nx     = asm_buf;
      gap_cnt_nx     = '0;
      nonce_nx       = nonce;
      nonce_valid_nx = 1'b0;
      frame_error_nx = 1'b0;
      case (rx_state)
         S_IDLE: begin
            rx_cnt_nx = '0;
            // the line is known high here (or held off after a bad stop), so low means a falling edge
            if (rx_hold) begin
               if (rx_sync) rx_hold_nx = 1'b0;
            end else if (!rx_sync) begin
               rx_state_nx = S_START;
            end
            if (asm_cnt != 2'd0) begin
               if (gap_cnt == GAP_LAST) asm_cnt_nx = '0;
               else                     gap_cnt_nx = gap_cnt + 1'b1;
            end
         end
         S_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_nx   = '0;
               rx_bit_nx   = '0;
               rx_state_nx = rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx   = '0;
               rx_shift_nx = {rx_sync, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_state_nx = S_STOP;
               else                rx_bit_nx   = rx_bit + 1'b1;
            end
         end
         S_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_nx   = '0;
               rx_state_nx = S_IDLE;
               if (rx_sync) begin
                  if (asm_cnt == 2'd3) begin
                     nonce_nx       = {rx_shift, asm_buf};
                     nonce_valid_nx = 1'b1;
                     asm_cnt_nx     = '0;
                  end else begin
                     case (asm_cnt)
                        2'd0:    asm_buf_nx[7:0]   = rx_shift;
                        2'd1:    asm_buf_nx[15:8]  = rx_shift;
                        default: asm_buf_nx[23:16] = rx_shift;
                     endcase
                     asm_cnt_nx = asm_cnt + 1'b1;
                  end
               end else begin
                  frame_error_nx = 1'b1;
                  asm_cnt_nx     = '0;
                  rx_hold_nx     = 1'b1;
               end
            end
         end
         default: rx_state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_work_sender.sv
// tb/tb_work_sender.sv - self-checking bench for work_sender with a frame-level model
`timescale 1ns/1ps
module tb_work_sender;
   localparam int GAP = 400;
   localparam int JOB_CYCLES = 10240;
   localparam logic [255:0] MS_A = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
   localparam logic [255:0] DS_A = 256'hA1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBFC0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         rx = 1'b1;
   logic [255:0] midstate = '0;
   logic [255:0] data2 = '0;
   logic         busy, tx, nonce_valid, frame_error;
   logic [31:0]  nonce;

   int chk = 0;
   int err = 0;
   int cyc = 0;

   work_sender #(.CLOCK(16), .BAUD(1), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .midstate(midstate), .data2(data2),
      .busy(busy), .tx(tx), .rx(rx), .nonce(nonce), .nonce_valid(nonce_valid),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic       m_active = 1'b0;
   int         m_off = 0;
   logic [7:0] m_bytes [64];
   logic [31:0] m_nonce = '0;
   logic [31:0] exp_nonce_q [$];
   int         exp_ferr = 0;
   int         nv_count = 0;
   int         fe_count = 0;
   logic [7:0] m_buf [4];
   int         m_cnt = 0;
   int         m_last_end = 0;

   function automatic logic exp_tx(input int o);
      int b = o / 160;
      int p = (o % 160) / 16;
      logic [7:0] v;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      v = m_bytes[b];
      return v[p-1];
   endfunction

   initial forever @(posedge clk) cyc++;

   initial forever begin
      logic was_active;
      @(posedge clk or posedge rst);
      if (rst) begin
         m_active = 1'b0;
      end else begin
         was_active = m_active;
         if (m_active) begin
            m_off++;
            if (m_off == JOB_CYCLES) m_active = 1'b0;
         end
         if (!was_active && start) begin
            m_active = 1'b1;
            m_off = 0;
            for (int k = 0; k < 32; k++) begin
               m_bytes[k]      = midstate[8*k +: 8];
               m_bytes[32 + k] = data2[8*k +: 8];
            end
         end
      end
   end

   // per-cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (m_active) begin
         check("tx_bit", tx, exp_tx(m_off));
         check("busy_job", busy, 1'b1);
      end else begin
         check("tx_idle", tx, 1'b1);
         check("busy_idle", busy, 1'b0);
      end
      if (rst) m_nonce = '0;
      if (nonce_valid) begin
         nv_count++;
         if (exp_nonce_q.size() == 0) begin
            chk++; err++;
            $display("FAIL nonce_valid_unexpected actual nonce=%0h required no pulse", nonce);
         end else begin
            m_nonce = exp_nonce_q.pop_front();
            check("nonce_value", nonce, m_nonce);
         end
      end else begin
         check("nonce_hold", nonce, m_nonce);
      end
      if (frame_error) begin
         fe_count++;
         chk++;
         if (exp_ferr == 0) begin
            err++;
            $display("FAIL frame_error_unexpected actual=1 required=0");
         end else exp_ferr--;
      end
   end

   // bench UART decoder on tx
   logic [7:0] dec_q [$];
   initial forever begin
      int d_state = 0;
      int d_cnt = 0;
      logic [7:0] d_byte = '0;
      forever begin
         @(negedge clk);
         if (rst) d_state = 0;
         else if (d_state == 0) begin
            if (!tx) begin d_state = 1; d_cnt = 0; end
         end else begin
            d_cnt++;
            if (d_cnt >= 24 && d_cnt <= 136 && (d_cnt % 16) == 8) d_byte[(d_cnt - 24) / 16] = tx;
            if (d_cnt == 152) begin
               check("dec_stop", tx, 1'b1);
               dec_q.push_back(d_byte);
               d_state = 0;
            end
         end
      end
   end

   int blen = 0;
   int last_blen = 0;
   initial forever begin
      @(negedge clk);
      if (rst) blen = 0;
      else if (busy) blen++;
      else if (blen != 0) begin last_blen = blen; blen = 0; end
   end

   // ---------------- stimulus ----------------
   task automatic send_bit(input logic v);
      rx = v;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      if (m_cnt != 0 && (cyc - m_last_end) >= GAP) m_cnt = 0;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (stop_ok) begin
         m_buf[m_cnt] = b;
         m_cnt++;
         if (m_cnt == 4) begin
            exp_nonce_q.push_back({m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
            m_cnt = 0;
         end
      end else begin
         exp_ferr++;
         m_cnt = 0;
      end
      send_bit(stop_ok);
      rx = 1'b1;
      m_last_end = cyc;
   endtask

   task automatic send_job(input logic [255:0] ms, input logic [255:0] d2);
      int n = 0;
      midstate = ms; data2 = d2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (busy && n < 12000) begin @(negedge clk); n++; end
      if (n >= 12000) begin
         chk++; err++;
         $display("FAIL job_timeout busy still high after %0d cycles, required low", n);
      end
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic verify_frame();
      logic [7:0] e;
      check("frame_len", dec_q.size(), 64);
      for (int k = 0; k < 64 && k < dec_q.size(); k++) begin
         e = (k < 32) ? 8'(8'h20 - k) : 8'(8'hC0 - (k - 32));
         check($sformatf("frame_byte%0d", k), dec_q[k], e);
      end
   endtask

   task automatic rx_settle(input string name);
      repeat (30) @(posedge clk); #1;
      check({name, "_pending"}, exp_nonce_q.size(), 0);
      check({name, "_ferr_pending"}, exp_ferr, 0);
   endtask

   initial begin
      #(700000);
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk); #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_nonce", nonce, 32'h0);
      check("rst_nonce_valid", nonce_valid, 1'b0);
      check("rst_frame_error", frame_error, 1'b0);
      rst = 1'b0;
      repeat (5) @(posedge clk); #1;

      // job plus an ignored start at cycle 500
      dec_q.delete();
      fork
         send_job(MS_A, DS_A);
         begin
            repeat (500) @(posedge clk); #1;
            midstate = ~MS_A; data2 = ~DS_A; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      verify_frame();
      check("busy_len", last_blen, JOB_CYCLES);

      // nonce reply alone
      nv_count = 0;
      send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
      rx_settle("reply");
      check("reply_nonce", nonce, 32'hDEADBEEF);
      check("reply_pulses", nv_count, 1);

      // nonce reply concurrent with a job
      nv_count = 0;
      dec_q.delete();
      fork
         send_job(MS_A, DS_A);
         begin
            repeat (300) @(posedge clk); #1;
            send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
            send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
         end
      join
      rx_settle("concurrent");
      verify_frame();
      check("concurrent_nonce", nonce, 32'hDEADBEEF);
      check("concurrent_pulses", nv_count, 1);

      // framing error on the second byte, then a clean reply
      nv_count = 0; fe_count = 0;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      repeat (20) @(posedge clk); #1;
      check("ferr_pulses", fe_count, 1);
      check("ferr_no_valid", nv_count, 0);
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      rx_settle("ferr");
      check("ferr_nonce", nonce, 32'h12345678);
      check("ferr_valid_pulses", nv_count, 1);

      // gap timeout drops a partial reply
      nv_count = 0;
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      repeat (500) @(posedge clk); #1;
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
      rx_settle("gap");
      check("gap_nonce", nonce, 32'h04030201);
      check("gap_pulses", nv_count, 1);

      // reset mid-frame, then a full frame
      midstate = MS_A; data2 = DS_A; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2999) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_nonce", nonce, 32'h0);
      m_cnt = 0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      dec_q.delete();
      send_job(MS_A, DS_A);
      verify_frame();
      check("post_rst_busy_len", last_blen, JOB_CYCLES);

      repeat (5) @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end
endmodule
